// File: rtl/bitserial_alu_ctrl.sv
// Bit-serial ALU sequencer: one 1-bit arithmetic slice, LSB first, result valid WIDTH+1 cycles after start.
// Define BITSERIAL_ALU_FLAGS_EN to build the signed-overflow and zero flags; otherwise they read 0.

module arithmetic_unit (
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_cin,
  input  logic [1:0] i_sel,
  output logic       o_d,
  output logic       o_cout
);
  logic w_m;

  // sel picks the second operand bit: 0, B, ~B or 1
  always_comb begin
    w_m = 1'b0;
    case (i_sel)
      2'b00:   w_m = 1'b0;
      2'b01:   w_m = i_b;
      2'b10:   w_m = ~i_b;
      default: w_m = 1'b1;
    endcase
  end

  assign o_d    = i_a ^ w_m ^ i_cin;
  assign o_cout = (i_a & w_m) | (i_cin & (i_a ^ w_m));
endmodule

module bitserial_alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       sel,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-2:0] r_dsh;
  logic [1:0]       r_sel;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_di;
  logic             w_co;
  logic [WIDTH-1:0] w_dnext;

  arithmetic_unit u_slice (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .i_sel  (r_sel),
    .o_d    (w_di),
    .o_cout (w_co)
  );

  // Partial result keeps only the WIDTH-1 bits already produced; the new bit completes the word
  assign w_dnext = {w_di, r_dsh};
  assign w_last  = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_dsh   <= '0;
      r_d     <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B;
      r_sel   <= sel;
      r_carry <= cin;
      r_cnt   <= '0;
      r_dsh   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_co;
      r_dsh   <= w_dnext[WIDTH-1:1];
      if (w_last) begin
        r_d    <= w_dnext;
        r_cout <= w_co;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign D    = r_d;
  assign cout = r_cout;

`ifdef BITSERIAL_ALU_FLAGS_EN
  logic r_ovf;
  logic r_zero;

  // r_carry holds the carry into the MSB during the final RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_last) begin
      r_ovf  <= r_carry ^ w_co;
      r_zero <= (w_dnext == '0);
    end
  end

  assign overflow = r_ovf;
  assign zero     = r_zero;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif
endmodule
